control_unit: RTL and testbench
===============================

# control_unit

Hard-wired, step-counter control unit for the 32-bit bus CPU. It sits directly upstream of the datapath. Each cycle it drives every datapath load, bus-enable, register-select and ALU-select line from its step state, the latched instruction (IR) and the CON flip-flop result. It sequences fetch, decode and execute for the full instruction set, stalls on a memory-ready handshake, and halts on `halt` or an illegal opcode.

## Interface
Parameters:
- `RESET_PC_STEP` = 0: step entered after reset (T0).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `clr`  in  1  reset; asynchronous, active-low.
- `IR`  in  32  instruction register contents; opcode = IR[31:27].
- `CON_out`  in  1  branch-condition result from the CON flip-flop.
- `mem_ready`  in  1  memory done with current `read`/`write`.
- `run`  out  1  1 while executing; 0 in HALT.
- `PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout`  out  1 each  bus drivers.
- `PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, outPort_in, CON_in`  out  1 each  register loads.
- `read, write`  out  1 each  memory strobes.
- `Gra, Grb, Grc, Rin, Rout, BAout`  out  1 each  select/encode controls.
- `ALU_select`  out  4  ALU operation.

## Operation
- States: T0–T7 and HALT. Outputs are Moore, decoded from state, opcode and `CON_out`. Every control line not listed for a step is 0.
- Fetch:
  - T0: PCout, MAR_in, Inc_PC.
  - T1: read, MDR_in. Hold T1 until `mem_ready`=1.
  - T2: MDRout, IR_in.
- ALU reg (add, sub, and, or, shr, shl, ror, rol):
  - T3: Grb, Rout, Y_in.
  - T4: Grc, Rout, ALU_select=op, Z_in.
  - T5: ZLOWout, Gra, Rin.
- ALU imm (addi, andi, ori): same as ALU reg, except T4 uses Cout in place of Grc/Rout.
- neg, not: T3 Grb, Rout, ALU_select=op, Z_in. T4 ZLOWout, Gra, Rin.
- ld:
  - T3: Grb, BAout, Y_in.
  - T4: Cout, ALU_ADD, Z_in.
  - T5: ZLOWout, MAR_in.
  - T6: read, MDR_in; wait on `mem_ready`.
  - T7: MDRout, Gra, Rin.
- ldi: T3–T4 as ld, then T5 ZLOWout, Gra, Rin.
- st:
  - T3–T5: as ld.
  - T6: Gra, Rout, MDR_in (read=0).
  - T7: write; wait on `mem_ready`.
- mul, div:
  - T3: Gra, Rout, Y_in.
  - T4: Grb, Rout, ALU_select, Z_in.
  - T5: ZLOWout, LO_in.
  - T6: ZHIout, HI_in.
- br:
  - T3: Gra, Rout, CON_in.
  - T4: PCout, Y_in.
  - T5: Cout, ALU_ADD, Z_in.
  - T6: if CON_out=1, ZLOWout and PC_in; else nothing.
- jal: T3 PCout, Grb, Rin (link register is the Rb field). T4 Gra, Rout, PC_in.
- jr: T3 Gra, Rout, PC_in.
- in, out, mfhi, mflo (each one step at T3):
  - in: inPortout, Gra, Rin.
  - out: Gra, Rout, outPort_in.
  - mfhi: HIout, Gra, Rin.
  - mflo: LOout, Gra, Rin.
- nop: T3 drives nothing.
- After the last execute step, the next state is T0.
- halt and any undefined opcode: go to HALT. HALT drives `run`=0 and all controls 0, and persists until `clr`.

## Timing
- Reset (`clr`=0, asynchronous): state=T0, all outputs 0 while asserted, `run`=1 once released.
- Datapath samples on the rising edge ending each step, so signals asserted in Tn take effect at that edge.
- Zero-wait latency in cycles, fetch included:
  - ALU reg, ALU imm: 6.
  - neg, not, jal: 5.
  - ld, st: 8.
  - ldi: 6.
  - mul, div, br: 7.
  - jr, in, out, mfhi, mflo, nop: 4.
- Each extra cycle with `mem_ready`=0 in T1 or a memory step adds one cycle. Outputs stay constant while waiting.
- `clr` asserted mid-instruction aborts it immediately; no partial write completes after reset.
- `mem_ready` is ignored outside T1 and the ld/st memory steps.

## Structure
- Package `cpu_pkg` holds:
  - opcode constants: ld=0, ldi=1, st=2, add..rol=3–10, addi/andi/ori=11–13, mul=14, div=15, neg=16, not=17, br=18, jr=19, jal=20, in=21, out=22, mfhi=23, mflo=24, nop=25, halt=26;
  - ALU_select codes;
  - the step enum.
- Natural sub-module: `ctrl_decode`, a combinational block mapping (step, opcode, CON_out) to the control word. The state register and step-advance/wait logic stay in `control_unit`.

## Test plan
- Reset with `clr`=0 mid-T4 → state T0, all controls 0; after release, the next cycle shows PCout=MAR_in=Inc_PC=1.
- IR=0x192B0000 (add R2,R5,R6), `mem_ready`=1 → T3 Grb/Rout/Y_in, T4 Grc/Rout/Z_in with ALU_select=ADD, T5 ZLOWout/Gra/Rin, then T0; 6 cycles total.
- ld with `mem_ready` low for 3 cycles in T6 → read=MDR_in=1 held 4 cycles; T7 MDRout/Gra/Rin; total 11 cycles.
- br, CON_out=0 → T6 drives no PC_in. Same instruction with CON_out=1 → T6 drives ZLOWout=PC_in=1.
- mul → T5 ZLOWout/LO_in, T6 ZHIout/HI_in, then T0.
- IR opcode 31 (undefined) → HALT after T2: `run`=0, all controls 0 for 20 cycles; `clr` pulse returns to T0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the bus CPU control unit: opcodes, ALU codes,
// step encoding, the control word and small decode helpers.
package cpu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_MUL  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;
  localparam logic [4:0] OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SHR = 4'd4;
  localparam logic [3:0] ALU_SHL = 4'd5;
  localparam logic [3:0] ALU_ROR = 4'd6;
  localparam logic [3:0] ALU_ROL = 4'd7;
  localparam logic [3:0] ALU_MUL = 4'd8;
  localparam logic [3:0] ALU_DIV = 4'd9;
  localparam logic [3:0] ALU_NEG = 4'd10;
  localparam logic [3:0] ALU_NOT = 4'd11;

  typedef enum logic [3:0] {
    S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } step_e;

  typedef struct packed {
    logic       pc_out;
    logic       zlow_out;
    logic       zhi_out;
    logic       lo_out;
    logic       hi_out;
    logic       mdr_out;
    logic       inport_out;
    logic       c_out;
    logic       pc_in;
    logic       inc_pc;
    logic       ir_in;
    logic       y_in;
    logic       z_in;
    logic       hi_in;
    logic       lo_in;
    logic       mar_in;
    logic       mdr_in;
    logic       outport_in;
    logic       con_in;
    logic       read;
    logic       write;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       ba_out;
    logic [3:0] alu_sel;
  } ctrl_word_t;

  function automatic logic [3:0] alu_op(input logic [4:0] op);
    case (op)
      OP_SUB:          return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR, OP_ORI:   return ALU_OR;
      OP_SHR:          return ALU_SHR;
      OP_SHL:          return ALU_SHL;
      OP_ROR:          return ALU_ROR;
      OP_ROL:          return ALU_ROL;
      OP_MUL:          return ALU_MUL;
      OP_DIV:          return ALU_DIV;
      OP_NEG:          return ALU_NEG;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_ADD;
    endcase
  endfunction

  // Final execute step of each instruction; after it the unit refetches.
  function automatic step_e last_step(input logic [4:0] op);
    case (op)
      OP_LD, OP_ST:                   return S_T7;
      OP_MUL, OP_DIV, OP_BR:          return S_T6;
      OP_NEG, OP_NOT, OP_JAL:         return S_T4;
      OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI:       return S_T5;
      default:                        return S_T3;
    endcase
  endfunction

  // halt and every unassigned opcode (27..31) stop the machine.
  function automatic logic is_halt_op(input logic [4:0] op);
    return op >= OP_HALT;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational decode of (step, opcode, CON) into the datapath control word.
module ctrl_decode
  import cpu_pkg::*;
(
  input  step_e       step,
  input  logic [4:0]  opcode,
  input  logic        con_out,
  output ctrl_word_t  cw
);

  // Every line defaults low; each step raises only the lines it needs.
  always_comb begin
    cw = '0;
    case (step)
      S_T0: begin cw.pc_out = 1'b1; cw.mar_in = 1'b1; cw.inc_pc = 1'b1; end
      S_T1: begin cw.read = 1'b1; cw.mdr_in = 1'b1; end
      S_T2: begin cw.mdr_out = 1'b1; cw.ir_in = 1'b1; end
      S_T3: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI: begin cw.grb = 1'b1; cw.rout = 1'b1; cw.y_in = 1'b1; end
          OP_NEG, OP_NOT: begin
            cw.grb = 1'b1; cw.rout = 1'b1; cw.alu_sel = alu_op(opcode); cw.z_in = 1'b1;
          end
          OP_LD, OP_LDI, OP_ST: begin cw.grb = 1'b1; cw.ba_out = 1'b1; cw.y_in = 1'b1; end
          OP_MUL, OP_DIV: begin cw.gra = 1'b1; cw.rout = 1'b1; cw.y_in = 1'b1; end
          OP_BR:   begin cw.gra = 1'b1; cw.rout = 1'b1; cw.con_in = 1'b1; end
          OP_JAL:  begin cw.pc_out = 1'b1; cw.grb = 1'b1; cw.rin = 1'b1; end
          OP_JR:   begin cw.gra = 1'b1; cw.rout = 1'b1; cw.pc_in = 1'b1; end
          OP_IN:   begin cw.inport_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          OP_OUT:  begin cw.gra = 1'b1; cw.rout = 1'b1; cw.outport_in = 1'b1; end
          OP_MFHI: begin cw.hi_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          OP_MFLO: begin cw.lo_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
            cw.grc = 1'b1; cw.rout = 1'b1; cw.alu_sel = alu_op(opcode); cw.z_in = 1'b1;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            cw.c_out = 1'b1; cw.alu_sel = alu_op(opcode); cw.z_in = 1'b1;
          end
          OP_NEG, OP_NOT: begin cw.zlow_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          OP_LD, OP_LDI, OP_ST: begin cw.c_out = 1'b1; cw.alu_sel = ALU_ADD; cw.z_in = 1'b1; end
          OP_MUL, OP_DIV: begin
            cw.grb = 1'b1; cw.rout = 1'b1; cw.alu_sel = alu_op(opcode); cw.z_in = 1'b1;
          end
          OP_BR:  begin cw.pc_out = 1'b1; cw.y_in = 1'b1; end
          OP_JAL: begin cw.gra = 1'b1; cw.rout = 1'b1; cw.pc_in = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
          OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin cw.zlow_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          OP_LD, OP_ST:   begin cw.zlow_out = 1'b1; cw.mar_in = 1'b1; end
          OP_MUL, OP_DIV: begin cw.zlow_out = 1'b1; cw.lo_in = 1'b1; end
          OP_BR: begin cw.c_out = 1'b1; cw.alu_sel = ALU_ADD; cw.z_in = 1'b1; end
          default: ;
        endcase
      end
      S_T6: begin
        case (opcode)
          OP_LD:          begin cw.read = 1'b1; cw.mdr_in = 1'b1; end
          OP_ST:          begin cw.gra = 1'b1; cw.rout = 1'b1; cw.mdr_in = 1'b1; end
          OP_MUL, OP_DIV: begin cw.zhi_out = 1'b1; cw.hi_in = 1'b1; end
          OP_BR:          begin cw.zlow_out = con_out; cw.pc_in = con_out; end
          default: ;
        endcase
      end
      S_T7: begin
        case (opcode)
          OP_LD:   begin cw.mdr_out = 1'b1; cw.gra = 1'b1; cw.rin = 1'b1; end
          OP_ST:   cw.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hard-wired step-counter control unit: step register, fetch/execute
// sequencing with memory-ready stalls, and halt handling.
module control_unit #(
  parameter int RESET_PC_STEP = 0
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_out,
  input  logic        mem_ready,
  output logic        run,
  output logic        PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout,
  output logic        PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
  output logic        outPort_in, CON_in,
  output logic        read, write,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic [3:0]  ALU_select
);
  import cpu_pkg::*;

  localparam step_e RST_STEP = step_e'(RESET_PC_STEP[3:0]);

  step_e      state_q, state_d;
  logic [4:0] opcode;
  logic       mem_step;
  logic       unused_ir;
  ctrl_word_t cw, cw_out;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];

  // Memory steps that must hold until the memory reports completion.
  assign mem_step = (state_q == S_T1) ||
                    (state_q == S_T6 && opcode == OP_LD) ||
                    (state_q == S_T7 && opcode == OP_ST);

  // Step register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state_q <= RST_STEP;
    else      state_q <= state_d;
  end

  // Step advance: stall on memory, halt on bad/halt opcode, wrap after last step.
  always_comb begin
    state_d = state_q;
    if (state_q == S_HALT) begin
      state_d = S_HALT;
    end else if (mem_step && !mem_ready) begin
      state_d = state_q;
    end else if (state_q == S_T2) begin
      state_d = is_halt_op(opcode) ? S_HALT : S_T3;
    end else if (state_q == S_T0 || state_q == S_T1) begin
      state_d = step_e'(state_q + 4'd1);
    end else if (state_q == last_step(opcode) || state_q == S_T7) begin
      state_d = S_T0;
    end else begin
      state_d = step_e'(state_q + 4'd1);
    end
  end

  ctrl_decode u_decode (
    .step    (state_q),
    .opcode  (opcode),
    .con_out (CON_out),
    .cw      (cw)
  );

  // Hold every control line low while reset is asserted.
  always_comb begin
    cw_out = clr ? cw : '0;
    run    = clr && (state_q != S_HALT);
  end

  assign PCout      = cw_out.pc_out;
  assign ZLOWout    = cw_out.zlow_out;
  assign ZHIout     = cw_out.zhi_out;
  assign LOout      = cw_out.lo_out;
  assign HIout      = cw_out.hi_out;
  assign MDRout     = cw_out.mdr_out;
  assign inPortout  = cw_out.inport_out;
  assign Cout       = cw_out.c_out;
  assign PC_in      = cw_out.pc_in;
  assign Inc_PC     = cw_out.inc_pc;
  assign IR_in      = cw_out.ir_in;
  assign Y_in       = cw_out.y_in;
  assign Z_in       = cw_out.z_in;
  assign HI_in      = cw_out.hi_in;
  assign LO_in      = cw_out.lo_in;
  assign MAR_in     = cw_out.mar_in;
  assign MDR_in     = cw_out.mdr_in;
  assign outPort_in = cw_out.outport_in;
  assign CON_in     = cw_out.con_in;
  assign read       = cw_out.read;
  assign write      = cw_out.write;
  assign Gra        = cw_out.gra;
  assign Grb        = cw_out.grb;
  assign Grc        = cw_out.grc;
  assign Rin        = cw_out.rin;
  assign Rout       = cw_out.rout;
  assign BAout      = cw_out.ba_out;
  assign ALU_select = cw_out.alu_sel;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-instruction step lists built from the
// instruction-set table, checked against the DUT every cycle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic        CON_out, mem_ready;
  logic        run, PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout;
  logic        PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in;
  logic        outPort_in, CON_in, read, write, Gra, Grb, Grc, Rin, Rout, BAout;
  logic [3:0]  ALU_select;

  control_unit #(.RESET_PC_STEP(0)) dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_out(CON_out), .mem_ready(mem_ready),
    .run(run), .PCout(PCout), .ZLOWout(ZLOWout), .ZHIout(ZHIout), .LOout(LOout),
    .HIout(HIout), .MDRout(MDRout), .inPortout(inPortout), .Cout(Cout),
    .PC_in(PC_in), .Inc_PC(Inc_PC), .IR_in(IR_in), .Y_in(Y_in), .Z_in(Z_in),
    .HI_in(HI_in), .LO_in(LO_in), .MAR_in(MAR_in), .MDR_in(MDR_in),
    .outPort_in(outPort_in), .CON_in(CON_in), .read(read), .write(write),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .ALU_select(ALU_select)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] RUN    = 32'h8000_0000, PCOUT  = 32'h4000_0000,
                          ZLOW   = 32'h2000_0000, ZHI    = 32'h1000_0000,
                          LOOUT  = 32'h0800_0000, HIOUT  = 32'h0400_0000,
                          MDROUT = 32'h0200_0000, INPOUT = 32'h0100_0000,
                          COUT   = 32'h0080_0000, PCIN   = 32'h0040_0000,
                          INCPC  = 32'h0020_0000, IRIN   = 32'h0010_0000,
                          YIN    = 32'h0008_0000, ZIN    = 32'h0004_0000,
                          HIIN   = 32'h0002_0000, LOIN   = 32'h0001_0000,
                          MARIN  = 32'h0000_8000, MDRIN  = 32'h0000_4000,
                          OUTPIN = 32'h0000_2000, CONIN  = 32'h0000_1000,
                          READ   = 32'h0000_0800, WRITE  = 32'h0000_0400,
                          GRA    = 32'h0000_0200, GRB    = 32'h0000_0100,
                          GRC    = 32'h0000_0080, RIN    = 32'h0000_0040,
                          ROUT   = 32'h0000_0020, BAOUT  = 32'h0000_0010;

  logic [31:0] dut_word;
  assign dut_word = {run, PCout, ZLOWout, ZHIout, LOout, HIout, MDRout, inPortout, Cout,
                     PC_in, Inc_PC, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in,
                     outPort_in, CON_in, read, write, Gra, Grb, Grc, Rin, Rout, BAout,
                     ALU_select};

  int          n_err = 0;
  int          n_chk = 0;
  logic        chk_en = 1'b0;
  logic [31:0] exp_word = '0;
  string       cur_tag = "idle";

  logic [31:0] exp_q[$];
  int          kind_q[$];   // 0 plain step, 1 fetch memory wait, 2 execute memory wait

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ALU codes the unit drives for each arithmetic opcode.
  function automatic logic [31:0] alu(input int op);
    case (op)
      3, 11:   return 32'd0;
      4:       return 32'd1;
      5, 12:   return 32'd2;
      6, 13:   return 32'd3;
      7:       return 32'd4;
      8:       return 32'd5;
      9:       return 32'd6;
      10:      return 32'd7;
      14:      return 32'd8;
      15:      return 32'd9;
      16:      return 32'd10;
      17:      return 32'd11;
      default: return 32'd0;
    endcase
  endfunction

  task automatic push(input logic [31:0] w, input int kind);
    exp_q.push_back(RUN | w);
    kind_q.push_back(kind);
  endtask

  // Reference: the list of control sets each instruction should walk through.
  task automatic model_instr(input int op, input logic con);
    exp_q.delete();
    kind_q.delete();
    push(PCOUT | MARIN | INCPC, 0);
    push(READ | MDRIN, 1);
    push(MDROUT | IRIN, 0);
    if (op >= 3 && op <= 10) begin
      push(GRB | ROUT | YIN, 0);
      push(GRC | ROUT | ZIN | alu(op), 0);
      push(ZLOW | GRA | RIN, 0);
    end else if (op >= 11 && op <= 13) begin
      push(GRB | ROUT | YIN, 0);
      push(COUT | ZIN | alu(op), 0);
      push(ZLOW | GRA | RIN, 0);
    end else if (op == 16 || op == 17) begin
      push(GRB | ROUT | ZIN | alu(op), 0);
      push(ZLOW | GRA | RIN, 0);
    end else if (op <= 2) begin
      push(GRB | BAOUT | YIN, 0);
      push(COUT | ZIN, 0);
      if (op == 1) push(ZLOW | GRA | RIN, 0);
      else begin
        push(ZLOW | MARIN, 0);
        if (op == 0) begin
          push(READ | MDRIN, 2);
          push(MDROUT | GRA | RIN, 0);
        end else begin
          push(GRA | ROUT | MDRIN, 0);
          push(WRITE, 2);
        end
      end
    end else if (op == 14 || op == 15) begin
      push(GRA | ROUT | YIN, 0);
      push(GRB | ROUT | ZIN | alu(op), 0);
      push(ZLOW | LOIN, 0);
      push(ZHI | HIIN, 0);
    end else if (op == 18) begin
      push(GRA | ROUT | CONIN, 0);
      push(PCOUT | YIN, 0);
      push(COUT | ZIN, 0);
      push(con ? (ZLOW | PCIN) : 32'h0, 0);
    end else if (op == 20) begin
      push(PCOUT | GRB | RIN, 0);
      push(GRA | ROUT | PCIN, 0);
    end else if (op == 19) push(GRA | ROUT | PCIN, 0);
    else if (op == 21) push(INPOUT | GRA | RIN, 0);
    else if (op == 22) push(GRA | ROUT | OUTPIN, 0);
    else if (op == 23) push(HIOUT | GRA | RIN, 0);
    else if (op == 24) push(LOOUT | GRA | RIN, 0);
    else if (op == 25) push(32'h0, 0);
    else begin
      for (int k = 0; k < 20; k++) begin
        exp_q.push_back(32'h0);
        kind_q.push_back(0);
      end
    end
  endtask

  // Drive one instruction; stalls hold mem_ready low, noise lowers it where it must be ignored.
  task automatic run_instr(input string tag, input logic [31:0] ir, input logic con,
                           input int t1_st, input int mem_st, input logic noise,
                           input int max_ent, output int cycles, output int reads);
    model_instr(int'(ir[31:27]), con);
    IR = ir;
    CON_out = con;
    cur_tag = tag;
    cycles = 0;
    reads = 0;
    for (int i = 0; i < exp_q.size() && i < max_ent; i++) begin
      int n;
      n = (kind_q[i] == 1) ? t1_st : (kind_q[i] == 2) ? mem_st : 0;
      for (int c = 0; c <= n; c++) begin
        exp_word = exp_q[i];
        mem_ready = (kind_q[i] == 0) ? ~noise : (c == n);
        chk_en = 1'b1;
        #1;
        if (read) reads++;
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    chk_en = 1'b0;
    mem_ready = 1'b1;
  endtask

  function automatic logic [31:0] mk(input int op);
    logic [4:0] o;
    o = op[4:0];
    return {o, 27'h0123456};
  endfunction

  // Cycle-by-cycle comparison against the reference list.
  always @(negedge clk) begin
    if (chk_en) check(cur_tag, dut_word, exp_word);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit, got no finish");
    $fatal(1, "time limit");
  end

  initial begin
    int cyc, rd;
    clr = 1'b0;
    IR = 32'h0;
    CON_out = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_all_low", dut_word, 32'h0);
    clr = 1'b1;
    #1;
    check("release_t0", dut_word, 32'hC020_8000);

    run_instr("add", 32'h192B_0000, 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    check("add_cycles", 32'(cyc), 32'd6);
    run_instr("sub", mk(4), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("rol", mk(10), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("addi_t1wait", mk(11), 1'b0, 2, 0, 1'b0, 99, cyc, rd);
    check("addi_cycles", 32'(cyc), 32'd8);
    run_instr("ori", mk(13), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("neg", mk(16), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    check("neg_cycles", 32'(cyc), 32'd5);
    run_instr("not", mk(17), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("ld_wait3", mk(0), 1'b0, 0, 3, 1'b0, 99, cyc, rd);
    check("ld_cycles", 32'(cyc), 32'd11);
    check("ld_read_cycles", 32'(rd), 32'd5);   // one in T1, four held in T6
    run_instr("ld", mk(0), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    check("ld_nowait_cycles", 32'(cyc), 32'd8);
    run_instr("ldi", mk(1), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    check("ldi_cycles", 32'(cyc), 32'd6);
    run_instr("st_wait2", mk(2), 1'b0, 0, 2, 1'b0, 99, cyc, rd);
    check("st_cycles", 32'(cyc), 32'd10);
    run_instr("mul_noise", mk(14), 1'b0, 0, 0, 1'b1, 99, cyc, rd);
    check("mul_cycles", 32'(cyc), 32'd7);
    run_instr("div", mk(15), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("br_con0", mk(18), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("br_con1", mk(18), 1'b1, 0, 0, 1'b0, 99, cyc, rd);
    check("br_cycles", 32'(cyc), 32'd7);
    run_instr("jal", mk(20), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    check("jal_cycles", 32'(cyc), 32'd5);
    run_instr("jr", mk(19), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("in", mk(21), 1'b0, 0, 0, 1'b1, 99, cyc, rd);
    run_instr("out", mk(22), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("mfhi", mk(23), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("mflo", mk(24), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    run_instr("nop", mk(25), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    check("nop_cycles", 32'(cyc), 32'd4);

    // Abort an add in the middle of T4.
    run_instr("add_partial", 32'h192B_0000, 1'b0, 0, 0, 1'b0, 4, cyc, rd);
    #2;
    check("mid_t4_word", dut_word, 32'h8004_00A0);
    clr = 1'b0;
    #1;
    check("clr_async_low", dut_word, 32'h0);
    @(posedge clk);
    #1;
    check("clr_held_low", dut_word, 32'h0);
    clr = 1'b1;
    #1;
    check("rerelease_t0", dut_word, 32'hC020_8000);
    run_instr("add_after_abort", 32'h192B_0000, 1'b0, 0, 0, 1'b0, 99, cyc, rd);

    run_instr("halt", mk(26), 1'b0, 0, 0, 1'b0, 99, cyc, rd);
    check("halt_run", {31'h0, run}, 32'h0);
    clr = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    #1;
    check("halt_exit_t0", dut_word, 32'hC020_8000);
    run_instr("illegal31", mk(31), 1'b0, 0, 0, 1'b1, 99, cyc, rd);
    check("illegal_cycles", 32'(cyc), 32'd23);
    clr = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b1;
    run_instr("nop_after_halt", mk(25), 1'b0, 0, 0, 1'b0, 99, cyc, rd);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
